// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg: shared state encoding and frame constants for the FIFO-fed UART transmitter
package fifo_uart_tx_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_WAIT  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;
  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 10;
endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// baud_gen: free-running bit timer, restartable by clear, pulses bit_end every CLKS_PER_BIT cycles
module baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] r_cnt;
  assign bit_end = (r_cnt == CW'(CLKS_PER_BIT - 1));
  // count cycles within a bit; restart at every bit boundary or state change
  always_ff @(posedge clk) begin
    if (rst || clear || bit_end) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a FIFO and serialises each as a UART 8N1 frame
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int RD_LATENCY   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_ren,
  output logic              tx,
  output logic              busy,
  output logic              tx_done,
  output logic [15:0]       frames_sent
);
  localparam int WW = $clog2(RD_LATENCY + 1);
  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_shift, w_shift;
  logic [2:0]        r_bit;
  logic [WW-1:0]     r_wcnt;
  logic [15:0]       r_frames;
  logic              r_tx, w_tx, w_bit_end, w_clear, w_wait_done;

  baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_clear),
    .bit_end(w_bit_end)
  );

  assign w_wait_done = (r_wcnt == WW'(RD_LATENCY - 1));
  assign w_clear     = (w_next != r_state);
  assign fifo_ren    = (r_state == S_POP);
  assign busy        = (r_state != S_IDLE);
  assign tx_done     = (r_state == S_STOP) && w_bit_end;
  assign tx          = r_tx;
  assign frames_sent = r_frames;

  // next state, next shift contents and the line level the next state will drive
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = (enable && !fifo_empty) ? S_POP : S_IDLE;
      S_POP:   w_next = S_WAIT;
      S_WAIT:  w_next = w_wait_done ? S_START : S_WAIT;
      S_START: w_next = w_bit_end ? S_DATA : S_START;
      S_DATA:  w_next = (w_bit_end && r_bit == 3'd7) ? S_STOP : S_DATA;
      S_STOP:  w_next = w_bit_end ? S_IDLE : S_STOP;
      default: w_next = S_IDLE;
    endcase
    w_shift = (r_state == S_WAIT && w_wait_done) ? fifo_rd_data :
              (r_state == S_DATA && w_bit_end) ? {1'b0, r_shift[DATA_W-1:1]} : r_shift;
    w_tx = (w_next == S_START) ? 1'b0 : (w_next == S_DATA) ? w_shift[0] : 1'b1;
  end

  // state, datapath and frame counter registers; tx is registered so the pin never glitches
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_tx     <= 1'b1;
      r_shift  <= '0;
      r_bit    <= '0;
      r_wcnt   <= '0;
      r_frames <= '0;
    end else begin
      r_state <= w_next;
      r_tx    <= w_tx;
      r_shift <= w_shift;
      r_bit   <= (r_state != S_DATA) ? 3'd0 : w_bit_end ? r_bit + 3'd1 : r_bit;
      r_wcnt  <= (r_state == S_WAIT) ? r_wcnt + 1'b1 : '0;
      if (tx_done) r_frames <= r_frames + 16'd1;
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench; a UART monitor decodes frames and checks them against queued bytes
module tb_fifo_uart_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_ren, tx, busy, tx_done;
  logic [15:0] frames_sent;

  int tests = 0, fails = 0, cyc = 0, ren_cnt = 0, last_end = -100;
  bit chk_gap = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  fifo_uart_tx #(.CLKS_PER_BIT(4), .RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_ren(fifo_ren), .tx(tx), .busy(busy),
    .tx_done(tx_done), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign fifo_empty = (fifo_q.size() == 0);
  always @(posedge clk) if (fifo_ren && fifo_q.size() != 0) fifo_rd_data <= fifo_q.pop_front();

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (frames_sent != 16'(n) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("frames_reach_%0d", n), frames_sent, n);
  endtask

  task automatic wait_start();
    int k = 0;
    while (tx !== 1'b0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("start_seen", tx, 0);
  endtask

  always @(negedge clk) if (fifo_ren) begin
    ren_cnt++;
    check("ren_while_nonempty", fifo_empty, 0);
  end

  initial begin : monitor
    logic [39:0] got, want, done_pat;
    logic [7:0] b;
    bit aborted;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && busy) begin
        if (chk_gap) check("gap_between_frames", cyc - last_end, 4);
        got = '0;
        done_pat = '0;
        done_pat[0] = tx_done;
        aborted = 0;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk);
          if (!busy) begin
            aborted = 1;
            break;
          end
          got[i] = tx;
          done_pat[i] = tx_done;
        end
        if (aborted) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          last_end = cyc;
          if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
          else begin
            b = exp_q.pop_front();
            for (int i = 0; i < 40; i++)
              want[i] = (i < 4) ? 1'b0 : (i >= 36) ? 1'b1 : b[i/4 - 1];
            tests++;
            if (got !== want) begin
              fails++;
              $display("FAIL frame_%02h: got %010h expected %010h", b, got, want);
            end
            check("tx_done_pattern", int'(done_pat[39:8]), 32'h8000_0000);
            check("tx_done_low_early", int'(done_pat[7:0]), 0);
          end
        end
      end
    end
  end

  initial begin
    int bad, r0;
    push(8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_ren", fifo_ren, 0);
      check("rst_busy", busy, 0);
      check("rst_frames", frames_sent, 0);
    end
    rst = 1'b0;
    wait_frames(1);
    check("t2_ren_pulses", ren_cnt, 1);
    @(negedge clk);
    push(8'h01); push(8'h02); push(8'h03);
    wait_frames(2);
    chk_gap = 1;
    wait_frames(4);
    @(negedge clk);
    chk_gap = 0;
    check("t3_ren_pulses", ren_cnt, 4);
    check("t3_fifo_empty", fifo_empty, 1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_ren !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("t4_idle_when_empty", bad, 0);
    push(8'h3C); push(8'hC3);
    wait_start();
    repeat (17) @(negedge clk);
    enable = 1'b0;
    wait_frames(5);
    r0 = ren_cnt;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    check("t5_no_pop_disabled", ren_cnt, r0);
    check("t5_idle_disabled", bad, 0);
    enable = 1'b1;
    wait_frames(6);
    check("t5_ren_pulses", ren_cnt, r0 + 1);
    push(8'h5A); push(8'h96);
    wait_start();
    repeat (25) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_tx_after_rst", tx, 1);
    check("t6_busy_after_rst", busy, 0);
    check("t6_frames_after_rst", frames_sent, 0);
    rst = 1'b0;
    wait_frames(1);
    repeat (4) @(negedge clk);
    check("t6_exp_drained", exp_q.size(), 0);
    check("t6_fifo_empty", fifo_empty, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
